// File: rtl/access_log_pkg.sv
// Shared definitions for the access log capture block.
// Holds the record kind encodings, the capture FSM state type, the packed
// record layout at the default widths, and the default parameter values.
package access_log_pkg;

  localparam int ID_W_D   = 4;
  localparam int TS_W_D   = 16;
  localparam int DEPTH_D  = 8;
  localparam int DROP_W_D = 8;

  localparam logic KIND_ACCESS = 1'b0;
  localparam logic KIND_DROP   = 1'b1;

  typedef enum logic {
    NORMAL   = 1'b0,
    OVERFLOW = 1'b1
  } state_e;

  // Record layout at default widths; the top packs the same field order
  // ({kind, ts, user, res}) for any parameterisation.
  typedef struct packed {
    logic              kind;
    logic [TS_W_D-1:0] ts;
    logic [ID_W_D-1:0] user;
    logic [ID_W_D-1:0] res;
  } rec_t;

endpackage

// File: rtl/access_log_fifo.sv
// Synchronous FIFO with first-word-fall-through read and occupancy output.
// Ports:
//   clk, rst      clock, async active-high reset
//   i_push        write request (ignored when full)
//   i_wdata       write data
//   i_pop         read request (ignored when empty)
//   o_rdata       head entry; zero while empty
//   o_empty       no entries
//   o_full        level == DEPTH (registered level)
//   o_level       current occupancy
module access_log_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [LW-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  // Full is judged on the registered level, so a same-cycle pop never
  // makes room for a write.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Gate the head so the stream reads zero while empty (and after reset).
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/access_log_capture.sv
// Consumer end of the user/resource access interface. Timestamps each valid
// access event, buffers records in a FWFT FIFO and streams them out over
// valid/ready. Events lost to a full FIFO are counted; when space returns a
// single drop-summary record is inserted where the gap occurred.
// Ports:
//   clk, rst                 clock, async active-high reset
//   ev_valid/user_id/
//   resource_id              incoming access event
//   rec_valid/rec_ready      output stream handshake
//   rec_kind/rec_ts/
//   rec_user/rec_res         head record (summary: count split user=hi, res=lo)
//   drop_count               cumulative dropped events, saturating
//   fifo_level               current FIFO occupancy
module access_log_capture
  import access_log_pkg::*;
#(
  parameter int ID_W   = ID_W_D,
  parameter int TS_W   = TS_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int DROP_W = DROP_W_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ev_valid,
  input  logic [ID_W-1:0]        user_id,
  input  logic [ID_W-1:0]        resource_id,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic                   rec_kind,
  output logic [TS_W-1:0]        rec_ts,
  output logic [ID_W-1:0]        rec_user,
  output logic [ID_W-1:0]        rec_res,
  output logic [DROP_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int CW    = 2 * ID_W;
  localparam int REC_W = 1 + TS_W + CW;
  localparam int LW    = $clog2(DEPTH) + 1;

  state_e            r_state, w_state_nxt;
  logic [TS_W-1:0]   r_ts;
  logic [CW-1:0]     r_pend, w_pend_nxt, w_pend_inc, w_sum;
  logic [DROP_W-1:0] r_drops;
  logic              w_drop_inc, w_push, w_full, w_empty;
  logic [REC_W-1:0]  w_wdata, w_rdata;

  access_log_fifo #(.W(REC_W), .DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (rec_ready),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign rec_valid = !w_empty;
  assign {rec_kind, rec_ts, rec_user, rec_res} = w_rdata;
  assign drop_count = r_drops;

  // Pending drop count, saturating; w_sum also folds in an event arriving
  // in the cycle the summary is written.
  assign w_pend_inc = (r_pend == '1) ? r_pend : r_pend + CW'(1);
  assign w_sum      = ev_valid ? w_pend_inc : r_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_drop_inc  = 1'b0;
    w_push      = 1'b0;
    w_wdata     = {KIND_ACCESS, r_ts, user_id, resource_id};
    case (r_state)
      NORMAL: begin
        if (ev_valid) begin
          if (w_full) begin
            w_drop_inc  = 1'b1;
            w_pend_nxt  = CW'(1);
            w_state_nxt = OVERFLOW;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      OVERFLOW: begin
        if (w_full) begin
          if (ev_valid) begin
            w_drop_inc = 1'b1;
            w_pend_nxt = w_pend_inc;
          end
        end else begin
          // Summary takes the slot; any event this cycle is dropped into it.
          w_push      = 1'b1;
          w_wdata     = {KIND_DROP, r_ts, w_sum};
          w_drop_inc  = ev_valid;
          w_pend_nxt  = '0;
          w_state_nxt = NORMAL;
        end
      end
      default: w_state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= NORMAL;
      r_ts    <= '0;
      r_pend  <= '0;
      r_drops <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + 1'b1;
      r_pend  <= w_pend_nxt;
      if (w_drop_inc && (r_drops != '1)) r_drops <= r_drops + 1'b1;
    end
  end

endmodule

// File: tb/tb_access_log_capture.sv
module tb_access_log_capture;
  import access_log_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, ev_valid = 1'b0, rec_ready = 1'b0;
  logic [3:0]  user_id = '0, resource_id = '0;
  logic        rec_valid, rec_kind;
  logic [15:0] rec_ts;
  logic [3:0]  rec_user, rec_res;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  access_log_capture #(.ID_W(4), .TS_W(16), .DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .user_id(user_id),
    .resource_id(resource_id), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_ts(rec_ts), .rec_user(rec_user), .rec_res(rec_res),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: queue of expected records plus overflow bookkeeping.
  rec_t q[$];
  bit   m_ovf;
  int   m_pend, m_drops, m_tcnt;

  task automatic model_clear();
    q.delete();
    m_ovf = 0; m_pend = 0; m_drops = 0; m_tcnt = 0;
  endtask

  // One clock: drive inputs, advance model by the spec rules, sample at +1.
  task automatic cycle(input bit ev, input logic [3:0] u, input logic [3:0] r, input bit rdy);
    bit   full, popping, push;
    rec_t nr;
    int   cnt;
    ev_valid = ev; user_id = u; resource_id = r; rec_ready = rdy;
    @(posedge clk);
    full    = (q.size() == 8);
    popping = rdy && (q.size() > 0);
    push    = 0;
    nr      = '0;
    if (!m_ovf) begin
      if (ev) begin
        if (full) begin
          m_ovf = 1; m_pend = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          push = 1;
          nr.kind = KIND_ACCESS; nr.ts = m_tcnt[15:0]; nr.user = u; nr.res = r;
        end
      end
    end else if (full) begin
      if (ev) begin
        if (m_pend < 255) m_pend++;
        if (m_drops < 255) m_drops++;
      end
    end else begin
      cnt = m_pend + (ev ? 1 : 0);
      if (cnt > 255) cnt = 255;
      push = 1;
      nr.kind = KIND_DROP; nr.ts = m_tcnt[15:0]; nr.user = cnt[7:4]; nr.res = cnt[3:0];
      if (ev && m_drops < 255) m_drops++;
      m_ovf = 0; m_pend = 0;
    end
    if (popping) void'(q.pop_front());
    if (push) q.push_back(nr);
    m_tcnt = (m_tcnt + 1) % 65536;
    #1;
  endtask

  task automatic do_reset();
    ev_valid = 0; rec_ready = 0;
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rec_valid); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    total++; if ({rec_kind, rec_ts, rec_user, rec_res} !== 25'd0) begin
      bad++; $display("FAIL reset_rec got=%h exp=0", {rec_kind, rec_ts, rec_user, rec_res});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_first();
    do_reset();
    cycle(1, 4'd3, 4'd7, 1);
    total++; if ({rec_valid, rec_kind, rec_ts, rec_user, rec_res} !== {1'b1, 1'b0, 16'd0, 4'd3, 4'd7}) begin
      bad++; $display("FAIL first_rec got v=%b k=%b ts=%0d u=%0d r=%0d exp v=1 k=0 ts=0 u=3 r=7",
                      rec_valid, rec_kind, rec_ts, rec_user, rec_res);
    end
    cycle(0, 4'd0, 4'd0, 1);
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL first_drain got=%b exp=0", rec_valid); end
  endtask

  task automatic test_burst();
    do_reset();
    repeat (10) cycle(0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4'(i), 4'(i + 1), 0);
    total++; if (fifo_level !== 4'd5) begin bad++; $display("FAIL burst_level got=%0d exp=5", fifo_level); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rec_valid !== 1'b1 || rec_ts !== 16'(10 + i) || rec_user !== 4'(i)) begin
        bad++; $display("FAIL burst_order[%0d] got v=%b ts=%0d u=%0d exp v=1 ts=%0d u=%0d",
                        i, rec_valid, rec_ts, rec_user, 10 + i, i);
      end
      cycle(0, 4'd0, 4'd0, 1);
    end
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL burst_empty got=%b exp=0", rec_valid); end
  endtask

  task automatic test_overflow(input bit ev_in_summary);
    int expc;
    expc = 3 + (ev_in_summary ? 1 : 0);
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1, 4'(i), 4'(i), 0);
    total++; if (fifo_level !== 4'd8 || drop_count !== 8'd3) begin
      bad++; $display("FAIL ovf_fill got lvl=%0d drop=%0d exp lvl=8 drop=3", fifo_level, drop_count);
    end
    cycle(0, 4'd0, 4'd0, 1);
    total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL ovf_pop got=%0d exp=7", fifo_level); end
    cycle(ev_in_summary, 4'd5, 4'd5, 0);
    total++; if (fifo_level !== 4'd8 || drop_count !== 8'(expc)) begin
      bad++; $display("FAIL ovf_summary_lvl got lvl=%0d drop=%0d exp lvl=8 drop=%0d", fifo_level, drop_count, expc);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i == 7) begin
        if (rec_kind !== 1'b1 || rec_user !== 4'd0 || rec_res !== 4'(expc)) begin
          bad++; $display("FAIL ovf_summary got k=%b u=%0d r=%0d exp k=1 u=0 r=%0d", rec_kind, rec_user, rec_res, expc);
        end
      end else if (rec_kind !== 1'b0 || rec_user !== 4'(i + 1)) begin
        bad++; $display("FAIL ovf_access[%0d] got k=%b u=%0d exp k=0 u=%0d", i, rec_kind, rec_user, i + 1);
      end
      cycle(0, 4'd0, 4'd0, 1);
    end
    cycle(1, 4'd9, 4'd9, 0);
    total++; if (rec_valid !== 1'b1 || rec_kind !== 1'b0 || rec_user !== 4'd9) begin
      bad++; $display("FAIL ovf_normal got v=%b k=%b u=%0d exp v=1 k=0 u=9", rec_valid, rec_kind, rec_user);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 4'(i), 4'(i), 0);
    cycle(1, 4'd1, 4'd1, 1);
    total++; if (fifo_level !== 4'd7 || drop_count !== 8'd1) begin
      bad++; $display("FAIL fullpop got lvl=%0d drop=%0d exp lvl=7 drop=1", fifo_level, drop_count);
    end
    cycle(1, 4'd2, 4'd2, 0);
    total++; if (fifo_level !== 4'd8 || drop_count !== 8'd2) begin
      bad++; $display("FAIL fullpop_next got lvl=%0d drop=%0d exp lvl=8 drop=2", fifo_level, drop_count);
    end
  endtask

  // Runs straight after test_full_pop without a reset, so drop_count is nonzero.
  task automatic test_reset_mid();
    repeat (4) cycle(0, 4'd0, 4'd0, 1);
    total++; if (fifo_level !== 4'(q.size()) || q.size() != 4 || drop_count !== 8'(m_drops)) begin
      bad++; $display("FAIL mid_pre got lvl=%0d drop=%0d exp lvl=4 drop=%0d", fifo_level, drop_count, m_drops);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (rec_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 8'd0) begin
      bad++; $display("FAIL mid_async got v=%b lvl=%0d drop=%0d exp 0 0 0", rec_valid, fifo_level, drop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cycle(1, 4'd4, 4'd4, 0);
    total++; if (rec_valid !== 1'b1 || rec_ts !== 16'd0) begin
      bad++; $display("FAIL mid_ts got v=%b ts=%0d exp v=1 ts=0", rec_valid, rec_ts);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (300) cycle(1, 4'd2, 4'd2, 0);
    total++; if (drop_count !== 8'hff) begin bad++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
    cycle(0, 4'd0, 4'd0, 1);
    cycle(0, 4'd0, 4'd0, 0);
    repeat (7) cycle(0, 4'd0, 4'd0, 1);
    total++; if (rec_kind !== 1'b1 || rec_user !== 4'hf || rec_res !== 4'hf) begin
      bad++; $display("FAIL sat_summary got k=%b u=%0d r=%0d exp k=1 u=15 r=15", rec_kind, rec_user, rec_res);
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      thr = (i < 500) ? 30 : (i < 1000) ? 85 : 55;
      cycle(($urandom % 100) < 70, 4'($urandom), 4'($urandom), ($urandom % 100) < thr);
      total++;
      if (rec_valid !== (q.size() > 0) || fifo_level !== 4'(q.size()) || drop_count !== 8'(m_drops) ||
          (q.size() > 0 && {rec_kind, rec_ts, rec_user, rec_res} !== q[0])) begin
        bad++;
        $display("FAIL random[%0d] got v=%b lvl=%0d drop=%0d rec=%h exp lvl=%0d drop=%0d rec=%h",
                 i, rec_valid, fifo_level, drop_count, {rec_kind, rec_ts, rec_user, rec_res},
                 q.size(), m_drops, (q.size() > 0) ? q[0] : '0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_ts [4];
    exp_ts[0] = 16'hfffe; exp_ts[1] = 16'hffff; exp_ts[2] = 16'h0000; exp_ts[3] = 16'h0001;
    do_reset();
    repeat (65534) cycle(0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 4'(i), 4'(i), 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rec_valid !== 1'b1 || rec_ts !== exp_ts[i] || rec_user !== 4'(i)) begin
        bad++; $display("FAIL wrap[%0d] got v=%b ts=%0d u=%0d exp v=1 ts=%0d u=%0d",
                        i, rec_valid, rec_ts, rec_user, exp_ts[i], i);
      end
      cycle(0, 4'd0, 4'd0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_burst();
    test_overflow(0);
    test_overflow(1);
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
